// File: rtl/cnn_img_pkg.sv
// rtl/cnn_img_pkg.sv - shared geometry, widths and loader state encoding
// Purpose: constants shared by the image loader, its RAM and its interface.
// Ports: none (package).
package cnn_img_pkg;

  localparam int IMG_W    = 28;
  localparam int IMG_H    = 28;
  localparam int N_PIXELS = IMG_W * IMG_H;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 8;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_PIXELS - 1);
  localparam logic [ADDR_W-1:0] DEPTH_ADDR = ADDR_W'(N_PIXELS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_LOAD = ST_LOAD,
    S_FULL = ST_FULL
  } state_t;

endpackage

// File: rtl/image_stream_loader_if.sv
// rtl/image_stream_loader_if.sv - pixel stream and dual read port bundle
// Purpose: groups the incoming pixel stream and the two CNN read ports.
// Ports (signals):
//   s_data/s_valid/s_last : pixel stream, source -> loader
//   s_ready               : loader -> source
//   rd_en/addr1/addr2     : read request, CNN -> loader
//   data_out1/data_out2   : registered read data, loader -> CNN
// Modports: master (stream source / reader), slave (loader).
interface image_stream_loader_if;
  import cnn_img_pkg::*;

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [DATA_W-1:0] data_out1;
  logic [DATA_W-1:0] data_out2;

  modport master (
    output s_data, s_valid, s_last, rd_en, addr1, addr2,
    input  s_ready, data_out1, data_out2
  );

  modport slave (
    input  s_data, s_valid, s_last, rd_en, addr1, addr2,
    output s_ready, data_out1, data_out2
  );

endinterface

// File: rtl/image_wr_ram.sv
// rtl/image_wr_ram.sv - frame RAM, one write port, two registered read ports
// Purpose: holds one N_PIXELS frame; contents are never reset.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (read registers only)
//   we/waddr/wdata  : write port
//   re              : read strobe for both ports (already gated by the caller)
//   raddr1/raddr2   : read addresses; out-of-range reads return 0
//   rdata1/rdata2   : registered read data, hold when re=0
module image_wr_ram
  import cnn_img_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  (* ram_style = "block" *) logic [DATA_W-1:0] mem [0:N_PIXELS-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata1 <= '0;
      rdata2 <= '0;
    end else if (re) begin
      rdata1 <= (raddr1 < DEPTH_ADDR) ? mem[raddr1] : '0;
      rdata2 <= (raddr2 < DEPTH_ADDR) ? mem[raddr2] : '0;
    end
  end

endmodule

// File: rtl/image_stream_loader.sv
// rtl/image_stream_loader.sv - loads one 28x28 frame from a pixel stream into RAM
// Purpose: accepts a byte stream, writes a row-major frame, exposes two read ports
//   once the frame is resident. Frame ownership handed off with start/release_frame.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : pulse, begin (re)loading a frame (ignored while loading)
//   release_frame   : pulse, consumer done with the frame
//   bus             : stream + read ports (slave modport)
//   busy            : loading
//   full            : frame resident and readable
//   frame_done      : one-cycle pulse on entering FULL
//   err             : sticky framing error, cleared by start or rst
//   checksum        : mod-2^16 sum of accepted pixels (only with IMG_LOADER_CHECKSUM_EN)
// Build option: IMG_LOADER_CHECKSUM_EN adds the checksum port and adder.
module image_stream_loader
  import cnn_img_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 release_frame,
  image_stream_loader_if.slave bus,
  output logic                 busy,
  output logic                 full,
  output logic                 frame_done,
  output logic                 err
`ifdef IMG_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]          checksum
`endif
);

  state_t            state;
  logic [ADDR_W-1:0] wr_addr;
  logic              accept;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;

  assign bus.s_ready = (state == S_LOAD);
  assign accept      = bus.s_valid & bus.s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_addr    <= '0;
      busy       <= 1'b0;
      full       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
`ifdef IMG_LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_LOAD;
            wr_addr <= '0;
            err     <= 1'b0;
            busy    <= 1'b1;
`ifdef IMG_LOADER_CHECKSUM_EN
            checksum <= '0;
`endif
          end
        end
        S_LOAD: begin
          if (accept) begin
`ifdef IMG_LOADER_CHECKSUM_EN
            checksum <= checksum + 16'(bus.s_data);
`endif
            if (wr_addr == LAST_ADDR) begin
              // The frame is complete by count; a missing s_last is only flagged.
              state      <= S_FULL;
              busy       <= 1'b0;
              full       <= 1'b1;
              frame_done <= 1'b1;
              if (!bus.s_last) begin
                err <= 1'b1;
              end
            end else if (bus.s_last) begin
              // Short frame: drop it, the partial RAM contents are never exposed.
              state <= S_IDLE;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              wr_addr <= wr_addr + ADDR_W'(1);
            end
          end
        end
        S_FULL: begin
          if (start) begin
            state   <= S_LOAD;
            wr_addr <= '0;
            err     <= 1'b0;
            busy    <= 1'b1;
            full    <= 1'b0;
`ifdef IMG_LOADER_CHECKSUM_EN
            checksum <= '0;
`endif
          end else if (release_frame) begin
            state <= S_IDLE;
            full  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          full  <= 1'b0;
        end
      endcase
    end
  end

  // Reads only while FULL and writes only while LOAD, so the ports never collide.
  image_wr_ram u_ram (
    .clk    (clk),
    .rst    (rst),
    .we     (accept),
    .waddr  (wr_addr),
    .wdata  (bus.s_data),
    .re     (bus.rd_en & full),
    .raddr1 (bus.addr1),
    .raddr2 (bus.addr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  assign bus.data_out1 = rdata1;
  assign bus.data_out2 = rdata2;

endmodule

// File: tb/tb_image_stream_loader.sv
// tb/tb_image_stream_loader.sv - directed self-checking bench for image_stream_loader
module tb_image_stream_loader;
  import cnn_img_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic release_frame;
  logic busy;
  logic full;
  logic frame_done;
  logic err;
`ifdef IMG_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  image_stream_loader_if bus();

  image_stream_loader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .release_frame (release_frame),
    .bus           (bus),
    .busy          (busy),
    .full          (full),
    .frame_done    (frame_done),
    .err           (err)
`ifdef IMG_LOADER_CHECKSUM_EN
    ,
    .checksum      (checksum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int pattern, input int i);
    case (pattern)
      1:       return 8'hFF;
      2:       return 8'((i * 37) ^ (i >> 3));
      default: return 8'(i % 16);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_release();
    release_frame = 1'b1;
    tick();
    release_frame = 1'b0;
  endtask

  task automatic read_pair(input int a1, input int a2);
    bus.addr1 = ADDR_W'(a1);
    bus.addr2 = ADDR_W'(a2);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  // Streams pixels base..base+npix-1; s_last only on index last_idx (-1: never).
  // done_cyc is the frame_done cycle relative to the cycle of the first accept.
  task automatic stream(input int npix, input int base, input int last_idx,
                        input int pattern, input int gap_pct,
                        output int done_cnt, output int done_cyc, output int ready_drops);
    int sent  = 0;
    int cyc   = 0;
    int first = -1;
    logic ready_seen;
    done_cnt    = 0;
    done_cyc    = -1;
    ready_drops = 0;
    while (sent < npix && cyc < 4000) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        bus.s_valid = 1'b0;
      end else begin
        bus.s_valid = 1'b1;
        bus.s_data  = pix(pattern, base + sent);
        bus.s_last  = ((base + sent) == last_idx);
      end
      ready_seen = bus.s_ready;
      if (!ready_seen) ready_drops++;
      @(posedge clk);
      #1;
      if (bus.s_valid && ready_seen) begin
        if (first < 0) first = cyc;
        sent++;
      end
      cyc++;
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc - first;
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    check("stream_sent", sent, npix);
    repeat (3) begin
      tick();
      if (frame_done) done_cnt++;
    end
  endtask

  task automatic verify_frame(input string tag, input int pattern);
    int bad = 0;
    for (int a = 0; a < N_PIXELS; a += 2) begin
      read_pair(a, a + 1);
      if (bus.data_out1 !== pix(pattern, a))     bad++;
      if (bus.data_out2 !== pix(pattern, a + 1)) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_full"},  full, 0);
    check({tag, "_done"},  frame_done, 0);
    check({tag, "_err"},   err, 0);
    check({tag, "_ready"}, bus.s_ready, 0);
    check({tag, "_dout1"}, bus.data_out1, 0);
    check({tag, "_dout2"}, bus.data_out2, 0);
  endtask

  int dcnt, dcyc, drops;

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    release_frame = 1'b0;
    bus.s_data    = '0;
    bus.s_valid   = 1'b0;
    bus.s_last    = 1'b0;
    bus.rd_en     = 1'b0;
    bus.addr1     = '0;
    bus.addr2     = '0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Continuous full frame
    pulse_start();
    check("t1_busy", busy, 1);
    check("t1_ready", bus.s_ready, 1);
    stream(N_PIXELS, 0, N_PIXELS - 1, 0, 0, dcnt, dcyc, drops);
    check("t1_done_latency", dcyc, 784);
    check("t1_done_count", dcnt, 1);
    check("t1_full", full, 1);
    check("t1_err", err, 0);
    check("t1_busy_low", busy, 0);
    read_pair(0, 783);
    check("t1_rd0", bus.data_out1, 8'h00);
    check("t1_rd783", bus.data_out2, 8'h0F);

    // Same frame with valid gaps, restarted from FULL
    pulse_start();
    stream(N_PIXELS, 0, N_PIXELS - 1, 0, 30, dcnt, dcyc, drops);
    check("t2_ready_drops", drops, 0);
    check("t2_done_count", dcnt, 1);
    check("t2_full", full, 1);
    verify_frame("t2_ram", 0);

    // start+release together in FULL: start wins, reads stop updating
    read_pair(5, 20);
    check("t4_rd5", bus.data_out1, 8'h05);
    check("t4_rd20", bus.data_out2, 8'h04);
    start         = 1'b1;
    release_frame = 1'b1;
    tick();
    start         = 1'b0;
    release_frame = 1'b0;
    check("t4_busy", busy, 1);
    check("t4_full", full, 0);
    check("t4_ready", bus.s_ready, 1);
    read_pair(9, 30);
    check("t4_hold1", bus.data_out1, 8'h05);
    check("t4_hold2", bus.data_out2, 8'h04);

    // Reset mid-load at pixel 300
    stream(300, 0, -1, 2, 0, dcnt, dcyc, drops);
    check("t5_no_done", dcnt, 0);
    rst = 1'b1;
    tick();
    check_all_zero("t5_rst");
    rst = 1'b0;
    tick();

    // Early s_last on the 500th pixel, then a clean reload
    pulse_start();
    stream(500, 0, 499, 2, 0, dcnt, dcyc, drops);
    check("t3_err", err, 1);
    check("t3_full", full, 0);
    check("t3_busy", busy, 0);
    check("t3_ready", bus.s_ready, 0);
    check("t3_no_done", dcnt, 0);
    pulse_start();
    check("t3_err_cleared", err, 0);
    check("t3_busy_again", busy, 1);
    stream(N_PIXELS, 0, N_PIXELS - 1, 0, 0, dcnt, dcyc, drops);
    check("t3_full_reload", full, 1);
    check("t3_err_reload", err, 0);
    check("t3_done_reload", dcnt, 1);
    verify_frame("t3_ram", 0);

    // Out-of-range read addresses
    read_pair(784, 17);
    check("t5_oob784", bus.data_out1, 8'h00);
    check("t5_rd17", bus.data_out2, 8'h01);
    read_pair(1023, 783);
    check("t5_oob1023", bus.data_out1, 8'h00);
    check("t5_rd783", bus.data_out2, 8'h0F);

    // Release frees the buffer; reads then hold
    pulse_release();
    check("rel_full", full, 0);
    check("rel_busy", busy, 0);
    check("rel_ready", bus.s_ready, 0);
    read_pair(3, 3);
    check("rel_hold1", bus.data_out1, 8'h00);
    check("rel_hold2", bus.data_out2, 8'h0F);

    // All-0xFF frame, start ignored mid-load, final pixel without s_last
    pulse_start();
    stream(100, 0, -1, 1, 0, dcnt, dcyc, drops);
    check("t6_first_part_done", dcnt, 0);
    pulse_start();
    check("t6_still_busy", busy, 1);
    stream(N_PIXELS - 100, 100, -1, 1, 0, dcnt, dcyc, drops);
    check("t6_full", full, 1);
    check("t6_err_no_last", err, 1);
    check("t6_done_count", dcnt, 1);
`ifdef IMG_LOADER_CHECKSUM_EN
    check("t6_checksum", checksum, (N_PIXELS * 255) % 65536);
`endif
    verify_frame("t6_ram", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
